// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial memory controller and its arbiter.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  typedef enum logic {
    GNT_ICACHE = 1'b0,
    GNT_LSB    = 1'b1
  } grant_e;

  localparam logic [1:0] SZ_BYTE    = 2'd0;
  localparam logic [1:0] SZ_HALF    = 2'd1;
  localparam logic [1:0] SZ_WORD    = 2'd2;
  localparam logic [1:0] IO_SEL_DEF = 2'b11;

  // Size code 3 is illegal and handled as a word.
  function automatic logic [2:0] len_of(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_rr_arbiter.sv
// Two-way round-robin grant between ICache and LSB; a tie goes to whoever was not served last.
module mem_rr_arbiter
  import mem_ctrl_pkg::*;
(
  input  logic   icache_req,
  input  logic   lsb_req,
  input  grant_e last_grant,
  output logic   gnt_valid,
  output grant_e gnt
);

  always_comb begin
    gnt_valid = icache_req | lsb_req;
    if (icache_req && lsb_req)
      gnt = (last_grant == GNT_LSB) ? GNT_ICACHE : GNT_LSB;
    else if (lsb_req)
      gnt = GNT_LSB;
    else
      gnt = GNT_ICACHE;
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial RAM/IO controller: arbitrates ICache fetches and LSB loads/stores,
// sequences multi-byte transfers and returns one-cycle ready pulses.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_SEL = IO_SEL_DEF
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        icache_req,
  input  logic [31:0] icache_addr,
  output logic [31:0] icache_ins,
  output logic        icache_ready,
  input  logic        lsb_req,
  input  logic        lsb_we,
  input  logic [1:0]  lsb_size,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic [31:0] lsb_rdata,
  output logic        lsb_ready,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  state_e      state_q, state_d;
  grant_e      last_grant_q, last_grant_d, src_q, src_d, gnt;
  logic        gnt_valid, accept, acc_we, acc_stall, io_stall;
  logic [31:0] acc_addr;
  logic [2:0]  acc_len;
  logic [1:0]  cap_idx;
  logic [2:0]  cnt_q, cnt_d, len_q, len_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rbuf_q, rbuf_d;
  logic [31:0] mem_a_q, mem_a_d, icache_ins_q, icache_ins_d, lsb_rdata_q, lsb_rdata_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d, icache_ready_q, icache_ready_d, lsb_ready_q, lsb_ready_d;

  mem_rr_arbiter u_arb (
    .icache_req (icache_req),
    .lsb_req    (lsb_req),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt        (gnt)
  );

  // The dead cycle after each pulse keeps a still-high request from being served twice.
  always_comb begin
    accept    = (state_q == ST_IDLE) && rdy_in && !icache_ready_q && !lsb_ready_q && gnt_valid;
    acc_addr  = (gnt == GNT_LSB) ? lsb_addr : icache_addr;
    acc_len   = (gnt == GNT_LSB) ? len_of(lsb_size) : 3'd4;
    acc_we    = (gnt == GNT_LSB) && lsb_we;
    acc_stall = (lsb_addr[17:16] == IO_SEL) && io_buffer_full;
    io_stall  = (addr_q[17:16] == IO_SEL) && io_buffer_full;
    cap_idx   = cnt_q[1:0] - 2'd1;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q        <= ST_IDLE;
      last_grant_q   <= GNT_LSB;
      src_q          <= GNT_ICACHE;
      cnt_q          <= '0;
      len_q          <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rbuf_q         <= '0;
      mem_a_q        <= '0;
      mem_dout_q     <= '0;
      mem_wr_q       <= 1'b0;
      icache_ins_q   <= '0;
      icache_ready_q <= 1'b0;
      lsb_rdata_q    <= '0;
      lsb_ready_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      src_q          <= src_d;
      cnt_q          <= cnt_d;
      len_q          <= len_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rbuf_q         <= rbuf_d;
      mem_a_q        <= mem_a_d;
      mem_dout_q     <= mem_dout_d;
      mem_wr_q       <= mem_wr_d;
      icache_ins_q   <= icache_ins_d;
      icache_ready_q <= icache_ready_d;
      lsb_rdata_q    <= lsb_rdata_d;
      lsb_ready_q    <= lsb_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (rdy_in) begin
      case (state_q)
        ST_IDLE:  if (accept) state_d = acc_we ? ST_WRITE : ST_READ;
        ST_READ:  if (cnt_q == len_q + 3'd1) state_d = ST_IDLE;
        ST_WRITE: if (cnt_q == len_q) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // While paused, mem_a keeps presenting the first uncaptured byte, so the sample
  // taken on the resume edge belongs to that byte and the stale one is dropped.
  always_comb begin
    last_grant_d   = last_grant_q;
    src_d          = src_q;
    cnt_d          = cnt_q;
    len_d          = len_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rbuf_d         = rbuf_q;
    mem_a_d        = mem_a_q;
    mem_dout_d     = mem_dout_q;
    mem_wr_d       = 1'b0;
    icache_ins_d   = icache_ins_q;
    icache_ready_d = 1'b0;
    lsb_rdata_d    = lsb_rdata_q;
    lsb_ready_d    = 1'b0;
    if (rdy_in) begin
      case (state_q)
        ST_IDLE: if (accept) begin
          addr_d       = acc_addr;
          len_d        = acc_len;
          wdata_d      = lsb_wdata;
          src_d        = gnt;
          last_grant_d = gnt;
          rbuf_d       = '0;
          mem_a_d      = acc_addr;
          mem_dout_d   = lsb_wdata[7:0];
          if (acc_we && acc_stall) begin
            cnt_d = 3'd0;
          end else begin
            mem_wr_d = acc_we;
            cnt_d    = 3'd1;
          end
        end
        ST_READ: begin
          if (cnt_q == len_q + 3'd1) begin
            if (src_q == GNT_LSB) begin
              lsb_rdata_d = rbuf_q;
              lsb_ready_d = 1'b1;
            end else begin
              icache_ins_d   = rbuf_q;
              icache_ready_d = 1'b1;
            end
          end else begin
            rbuf_d[{cap_idx, 3'b000} +: 8] = mem_din;
            if (cnt_q < len_q) mem_a_d = addr_q + {29'd0, cnt_q};
            cnt_d = cnt_q + 3'd1;
          end
        end
        ST_WRITE: begin
          if (cnt_q == len_q) begin
            lsb_ready_d = 1'b1;
          end else if (!io_stall) begin
            mem_a_d    = addr_q + {29'd0, cnt_q};
            mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
            mem_wr_d   = 1'b1;
            cnt_d      = cnt_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign icache_ins   = icache_ins_q;
  assign icache_ready = icache_ready_q;
  assign lsb_rdata    = lsb_rdata_q;
  assign lsb_ready    = lsb_ready_q;
  assign mem_dout     = mem_dout_q;
  assign mem_a        = mem_a_q;
  assign mem_wr       = mem_wr_q;

endmodule
